bitmap_bound_alu: RTL and testbench



---
 rtl/bitmap_pkg.sv | 31 +++
 rtl/bitmap_bound_alu_if.sv | 14 +
 rtl/bitmap_zero_count.sv | 27 ++
 rtl/bitmap_bound_alu.sv | 133 +++++++++++++
 tb/tb_bitmap_bound_alu.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bitmap_pkg.sv
// Shared types and sizing helpers for the glyph bitmap bounding-box ALU,
// also used by the bitmap fetch unit and the note scaler.
package bitmap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REDUCE  = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int W_DEF          = 24;
    localparam int H_DEF          = 64;
    localparam int HSCALE_MIN_DEF = 12;
    localparam int VSCALE_MIN_DEF = 32;

    // Column-index / column-shift width: must hold the value W itself.
    function automatic int cw_of(input int w);
        return $clog2(w + 1);
    endfunction

    // Row-shift width: must hold the value H itself (all-zero row mask).
    function automatic int rw_of(input int h);
        return $clog2(h + 1);
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bitmap_bound_alu_if.sv
// Column stream from the bitmap fetch unit: one H-bit column per valid/ready handshake.
interface bitmap_bound_alu_if
    import bitmap_pkg::*;
#(
    parameter int H = H_DEF
);
    logic         col_valid;
    logic [H-1:0] col_data;
    logic         col_ready;

    modport master (output col_valid, output col_data, input col_ready);
    modport slave  (input col_valid, input col_data, output col_ready);

endinterface

// File: rtl/bitmap_zero_count.sv
// Combinational zero count of an N-bit vector from the top (LEADING=1) or the
// bottom (LEADING=0); an all-zero vector returns N.
module bitmap_zero_count #(
    parameter int N       = 64,
    parameter bit LEADING = 1'b1,
    parameter int NW      = $clog2(N + 1)
) (
    input  logic [N-1:0]  vec,
    output logic [NW-1:0] count
);

    // The last matching bit in scan order wins: the highest set bit for the
    // leading count, the lowest set bit for the trailing count.
    always_comb begin
        count = NW'(N);
        if (LEADING) begin
            for (int i = 0; i < N; i++) begin
                if (vec[i]) count = NW'(N - 1 - i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (vec[i]) count = NW'(i);
            end
        end
    end

endmodule

// File: rtl/bitmap_bound_alu.sv
// Glyph bitmap bounding-box ALU: streams W columns, then reports the empty
// margins on all four sides plus 2x-scale and empty flags.
module bitmap_bound_alu
    import bitmap_pkg::*;
#(
    parameter int W          = W_DEF,
    parameter int H          = H_DEF,
    parameter int HSCALE_MIN = HSCALE_MIN_DEF,
    parameter int VSCALE_MIN = VSCALE_MIN_DEF,
    parameter int CW         = cw_of(W),
    parameter int RW         = rw_of(H)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    bitmap_bound_alu_if.slave    col_if,
    output logic                 busy,
    output logic                 done,
    output logic [CW-1:0]        lshift,
    output logic [CW-1:0]        rshift,
    output logic [RW-1:0]        ushift,
    output logic [RW-1:0]        dshift,
    output logic                 scale_h,
    output logic                 scale_v,
    output logic                 empty
);

    localparam int SW = max_of(CW, RW) + 1;

    state_t        state, state_nxt;
    logic          accept;
    logic          last_col;
    logic [CW-1:0] col_cnt;
    logic [CW-1:0] first_idx;
    logic [CW-1:0] last_idx;
    logic          seen;
    logic [H-1:0]  row_mask;
    logic [RW-1:0] lead_zeros;
    logic [RW-1:0] trail_zeros;
    logic [CW-1:0] lshift_nxt, rshift_nxt;
    logic [RW-1:0] ushift_nxt, dshift_nxt;
    logic [SW-1:0] hsum, vsum;
    logic          scale_h_nxt, scale_v_nxt;

    // A column offered in the same cycle as start belongs to the aborted bitmap.
    assign accept   = col_if.col_valid && (state == COLLECT) && !start;
    assign last_col = (col_cnt == CW'(W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        col_if.col_ready = 1'b0;
        busy             = 1'b1;
        done             = 1'b0;
        case (state)
            IDLE: busy = 1'b0;
            COLLECT: begin
                col_if.col_ready = 1'b1;
                if (accept && last_col) state_nxt = REDUCE;
            end
            REDUCE: state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (start) state_nxt = COLLECT;
    end

    bitmap_zero_count #(.N(H), .LEADING(1'b1), .NW(RW)) u_lead (
        .vec   (row_mask),
        .count (lead_zeros)
    );

    bitmap_zero_count #(.N(H), .LEADING(1'b0), .NW(RW)) u_trail (
        .vec   (row_mask),
        .count (trail_zeros)
    );

    // Reduction: an empty bitmap forces every margin and flag to zero.
    always_comb begin
        lshift_nxt  = seen ? first_idx : '0;
        rshift_nxt  = seen ? (CW'(W - 1) - last_idx) : '0;
        ushift_nxt  = seen ? lead_zeros : '0;
        dshift_nxt  = seen ? trail_zeros : '0;
        hsum        = SW'(lshift_nxt) + SW'(rshift_nxt);
        vsum        = SW'(ushift_nxt) + SW'(dshift_nxt);
        scale_h_nxt = seen && (hsum >= SW'(HSCALE_MIN));
        scale_v_nxt = seen && (vsum >= SW'(VSCALE_MIN));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || start) begin
            col_cnt   <= '0;
            first_idx <= '0;
            last_idx  <= '0;
            seen      <= 1'b0;
            row_mask  <= '0;
            lshift    <= '0;
            rshift    <= '0;
            ushift    <= '0;
            dshift    <= '0;
            scale_h   <= 1'b0;
            scale_v   <= 1'b0;
            empty     <= 1'b0;
        end else begin
            if (accept) begin
                col_cnt  <= col_cnt + 1'b1;
                row_mask <= row_mask | col_if.col_data;
                if (|col_if.col_data) begin
                    if (!seen) first_idx <= col_cnt;
                    last_idx <= col_cnt;
                    seen     <= 1'b1;
                end
            end
            if (state == REDUCE) begin
                lshift  <= lshift_nxt;
                rshift  <= rshift_nxt;
                ushift  <= ushift_nxt;
                dshift  <= dshift_nxt;
                scale_h <= scale_h_nxt;
                scale_v <= scale_v_nxt;
                empty   <= !seen;
            end
        end
    end

endmodule

// File: tb/tb_bitmap_bound_alu.sv
// Scoreboard bench for bitmap_bound_alu: drivers queue hand-computed results,
// a monitor pops and compares them on every done pulse.
module tb_bitmap_bound_alu;
    import bitmap_pkg::*;

    localparam int W  = 24;
    localparam int H  = 64;
    localparam int CW = 5;
    localparam int RW = 7;

    typedef struct {
        int l, r, u, d, sh, sv, em;
        int done_cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, scale_h, scale_v, empty;
    logic [CW-1:0] lshift, rshift;
    logic [RW-1:0] ushift, dshift;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    bitmap_bound_alu_if #(.H(H)) bus ();

    bitmap_bound_alu #(.W(W), .H(H), .HSCALE_MIN(12), .VSCALE_MIN(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .col_if  (bus),
        .busy    (busy),
        .done    (done),
        .lshift  (lshift),
        .rshift  (rshift),
        .ushift  (ushift),
        .dshift  (dshift),
        .scale_h (scale_h),
        .scale_v (scale_v),
        .empty   (empty)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t mk(input int l, r, u, d, sh, sv, em);
        exp_t x;
        x.l = l; x.r = r; x.u = u; x.d = d;
        x.sh = sh; x.sv = sv; x.em = em;
        x.done_cyc = 0;
        return x;
    endfunction

    function automatic logic [H-1:0] col_of(input int pat, input int idx);
        case (pat)
            0: return (idx == 5) ? 64'h0000_0000_0000_0400 : '0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return (idx >= 6 && idx <= 17) ? 64'h0000_FFFF_FFFF_0000 : '0;
            4: return (idx >= 6 && idx <= 18) ? 64'h0001_FFFF_FFFF_0000 : '0;
            default: return '0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                chk("lshift", int'(lshift), x.l);
                chk("rshift", int'(rshift), x.r);
                chk("ushift", int'(ushift), x.u);
                chk("dshift", int'(dshift), x.d);
                chk("scale_h", int'(scale_h), x.sh);
                chk("scale_v", int'(scale_v), x.sv);
                chk("empty", int'(empty), x.em);
                chk("done_cycle", cyc, x.done_cyc);
                chk("ready_in_done", int'(bus.col_ready), 0);
            end
        end
    end

    // Called at a negedge; pulses start (with a junk column offered alongside),
    // then streams W columns, optionally with random valid gaps.
    task automatic run_bitmap(input int pat, input bit bp, input exp_t e_in);
        exp_t e;
        int   acc;
        int   guard;
        e     = e_in;
        acc   = 0;
        guard = 0;
        start = 1'b1;
        bus.col_valid = 1'b1;
        bus.col_data  = '1;
        @(negedge clk);
        start = 1'b0;
        chk("cleared_lshift", int'(lshift), 0);
        chk("cleared_ushift", int'(ushift), 0);
        while (acc < W && guard < 2000) begin
            guard++;
            bus.col_valid = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            bus.col_data  = col_of(pat, acc);
            if (bus.col_valid && bus.col_ready) begin
                acc++;
                if (acc == W) begin
                    e.done_cyc = cyc + 2;
                    exp_q.push_back(e);
                end
            end
            @(negedge clk);
        end
        if (acc < W) chk("stream_timeout", acc, W);
        chk("ready_in_reduce", int'(bus.col_ready), 0);
        chk("busy_in_reduce", int'(busy), 1);
        for (int k = 0; k < 2; k++) begin
            bus.col_valid = 1'b1;
            bus.col_data  = '1;
            if (bus.col_valid && bus.col_ready) acc++;
            @(negedge clk);
        end
        bus.col_valid = 1'b0;
        chk("accept_count", acc, W);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.col_valid = 1'b0;
        bus.col_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_lshift", int'(lshift), 0);
        chk("rst_empty", int'(empty), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", int'(bus.col_ready), 0);
        chk("idle_busy", int'(busy), 0);

        run_bitmap(0, 1'b0, mk(5, 18, 53, 10, 1, 1, 0));
        wait_drain();
        repeat (3) @(negedge clk);
        chk("hold_lshift", int'(lshift), 5);
        chk("hold_ushift", int'(ushift), 53);
        chk("hold_ready", int'(bus.col_ready), 0);

        run_bitmap(1, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
        wait_drain();
        run_bitmap(2, 1'b0, mk(0, 0, 0, 0, 0, 0, 1));
        wait_drain();
        run_bitmap(3, 1'b0, mk(6, 6, 16, 16, 1, 1, 0));
        wait_drain();
        run_bitmap(4, 1'b0, mk(6, 5, 15, 16, 0, 0, 0));
        wait_drain();

        // Asynchronous reset while results are being held.
        #2 rst = 1'b1;
        #1;
        chk("arst_hold_rshift", int'(rshift), 0);
        chk("arst_hold_ushift", int'(ushift), 0);
        chk("arst_hold_dshift", int'(dshift), 0);
        chk("arst_hold_lshift", int'(lshift), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_bitmap(3, 1'b1, mk(6, 6, 16, 16, 1, 1, 0));
        wait_drain();

        // Abort after 10 full columns; only the following bitmap must count.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.col_valid = 1'b1;
            bus.col_data  = '1;
            @(negedge clk);
        end
        run_bitmap(0, 1'b0, mk(5, 18, 53, 10, 1, 1, 0));
        wait_drain();

        // Asynchronous reset in the middle of a stream.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.col_valid = 1'b1;
            bus.col_data  = '1;
            @(negedge clk);
        end
        bus.col_valid = 1'b0;
        chk("mid_busy_before_rst", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_ready", int'(bus.col_ready), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_empty", int'(empty), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_bitmap(0, 1'b1, mk(5, 18, 53, 10, 1, 1, 0));
        wait_drain();
        repeat (2) @(negedge clk);
        chk("queue_empty_at_end", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
